// File: rtl/rr_dff_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_dff_reg_arbiter
//  Description : Round-robin write arbiter sharing one W-bit register among
//                N requesters. One registered grant per 2 cycles, one-cycle
//                acknowledge when the granted write commits.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_dff_reg_arbiter #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  wr_data,
    input  logic            freeze,
    output logic [N-1:0]    gnt,
    output logic            ack,
    output logic [IW-1:0]   ack_id,
    output logic [W-1:0]    q,
    output logic [IW-1:0]   owner,
    output logic            busy
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Sum width holds ptr + k for k up to N, i.e. at most 2N-1.
    localparam int          c_SW    = IW + 1;
    localparam logic [c_SW-1:0] c_N    = c_SW'(N);
    localparam logic [IW-1:0]   c_LAST = IW'(N - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [N-1:0]       r_gnt;
    logic               r_ack;
    logic [IW-1:0]      r_ack_id;
    logic [W-1:0]       r_q;
    logic [IW-1:0]      r_owner;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_win;

    logic               w_found;
    logic [IW-1:0]      w_win;
    logic [c_SW-1:0]    w_sum;
    logic               w_start;
    logic               w_commit;

    // Scan ptr+1, ptr+2, ... modulo N and take the first active request.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 1; k <= N; k++) begin
            w_sum = {1'b0, r_ptr} + c_SW'(k);
            if (w_sum >= c_N) begin
                w_sum = w_sum - c_N;
            end
            if (!w_found && req[w_sum[IW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[IW-1:0];
            end
        end
    end

    assign w_start  = (r_state == IDLE) && !freeze && w_found;
    assign w_commit = (r_state == GRANT) && req[r_win];

    // Next-state decision: a grant always lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = GRANT;
            GRANT:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, shared register, ownership and round-robin pointer updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gnt    <= '0;
            r_ack    <= 1'b0;
            r_ack_id <= '0;
            r_q      <= '0;
            r_owner  <= '0;
            r_ptr    <= c_LAST;
            r_win    <= '0;
        end else begin
            r_ack <= 1'b0;
            r_gnt <= '0;
            if (w_start) begin
                r_gnt <= N'(1) << w_win;
                r_win <= w_win;
            end
            // A withdrawn request leaves q, owner and the pointer untouched.
            if (w_commit) begin
                r_q      <= wr_data[int'(r_win)*W +: W];
                r_owner  <= r_win;
                r_ptr    <= r_win;
                r_ack    <= 1'b1;
                r_ack_id <= r_win;
            end
        end
    end

    assign gnt    = r_gnt;
    assign ack    = r_ack;
    assign ack_id = r_ack_id;
    assign q      = r_q;
    assign owner  = r_owner;
    assign busy   = (r_state == GRANT);

endmodule
`default_nettype wire

// File: tb/tb_rr_dff_reg_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_dff_reg_arbiter
//  Description : Self-checking bench for rr_dff_reg_arbiter. Expected writes
//                are queued at stimulus time and retired on each ack.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rr_dff_reg_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*W-1:0]  wr_data;
    logic            freeze;
    logic [N-1:0]    gnt;
    logic            ack;
    logic [IW-1:0]   ack_id;
    logic [W-1:0]    q;
    logic [IW-1:0]   owner;
    logic            busy;

    int   checks;
    int   errors;
    exp_t sb[$];

    rr_dff_reg_arbiter #(.N(N), .W(W), .IW(IW)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_data (wr_data),
        .freeze  (freeze),
        .gnt     (gnt),
        .ack     (ack),
        .ack_id  (ack_id),
        .q       (q),
        .owner   (owner),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Retire queued writes on every ack and watch grant sanity every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ($countones(gnt) > 1 || (!busy && gnt != '0)) begin
                errors++;
                $display("FAIL gnt_shape: gnt=%b busy=%b, required one-hot only while busy", gnt, busy);
            end
            if (ack) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected_ack: ack_id=%0d q=%h, required no ack", ack_id, q);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (ack_id !== e.id || q !== e.data || owner !== e.id) begin
                        errors++;
                        $display("FAIL sb_write: ack_id=%0d q=%h owner=%0d, required ack_id=%0d q=%h owner=%0d",
                                 ack_id, q, owner, e.id, e.data, e.id);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        req     = 4'b1111;
        freeze  = 1'b0;
        wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (gnt !== 4'b0000 || ack !== 1'b0 || q !== 8'h00 || owner !== 2'd0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: gnt=%b ack=%b q=%h owner=%0d busy=%b, required all zero",
                         gnt, ack, q, owner, busy);
            end
        end
        reset = 1'b0;
        sb.push_back('{id: 2'd0, data: 8'h11});
        cycle();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: gnt=%b, required 0001", gnt);
        end
        cycle();
        req = '0;
        cycle();
    endtask

    task automatic test_single();
        req     = 4'b0100;
        wr_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        sb.push_back('{id: 2'd2, data: 8'hA5});
        cycle();
        checks++;
        if (gnt !== 4'b0100 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt: gnt=%b busy=%b, required 0100 busy=1", gnt, busy);
        end
        cycle();
        checks++;
        if (ack !== 1'b1 || ack_id !== 2'd2 || q !== 8'hA5 || owner !== 2'd2) begin
            errors++;
            $display("FAIL single_ack: ack=%b ack_id=%0d q=%h owner=%0d, required 1 2 a5 2",
                     ack, ack_id, q, owner);
        end
        req = '0;
        cycle();
        checks++;
        if (ack !== 1'b0 || q !== 8'hA5 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_ack_drop: ack=%b q=%h gnt=%b, required 0 a5 0000", ack, q, gnt);
        end
    endtask

    task automatic test_rotation();
        logic [W-1:0] data [N];
        int           order [5];
        data  = '{8'h11, 8'h22, 8'h33, 8'h44};
        order = '{0, 1, 2, 3, 0};
        apply_reset();
        wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req     = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{id: IW'(order[i]), data: data[order[i]]});
        end
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (gnt !== (4'b0001 << order[i])) begin
                errors++;
                $display("FAIL rotation_gnt[%0d]: gnt=%b, required requester %0d", i, gnt, order[i]);
            end
            cycle();
            checks++;
            if (ack !== 1'b1 || ack_id !== IW'(order[i]) || q !== data[order[i]]) begin
                errors++;
                $display("FAIL rotation_ack[%0d]: ack=%b ack_id=%0d q=%h, required 1 %0d %h",
                         i, ack, ack_id, q, order[i], data[order[i]]);
            end
        end
        req = '0;
        cycle();
    endtask

    task automatic test_withdraw();
        apply_reset();
        wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req     = 4'b0010;
        cycle();
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL withdraw_gnt: gnt=%b, required 0010", gnt);
        end
        req = '0;
        cycle();
        checks++;
        if (ack !== 1'b0 || q !== 8'h00 || owner !== 2'd0) begin
            errors++;
            $display("FAIL withdraw_nowrite: ack=%b q=%h owner=%0d, required 0 00 0", ack, q, owner);
        end
        req = 4'b0011;
        sb.push_back('{id: 2'd0, data: 8'h11});
        cycle();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL withdraw_ptr: gnt=%b, required 0001", gnt);
        end
        cycle();
        req = '0;
        cycle();
    endtask

    task automatic test_freeze();
        freeze  = 1'b1;
        req     = 4'b1000;
        wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
        for (int i = 0; i < 5; i++) begin
            cycle();
            checks++;
            if (gnt !== 4'b0000) begin
                errors++;
                $display("FAIL freeze_hold[%0d]: gnt=%b, required 0000", i, gnt);
            end
        end
        freeze = 1'b0;
        sb.push_back('{id: 2'd3, data: 8'h44});
        cycle();
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL freeze_release: gnt=%b, required 1000", gnt);
        end
        freeze = 1'b1;
        cycle();
        checks++;
        if (ack !== 1'b1 || ack_id !== 2'd3) begin
            errors++;
            $display("FAIL freeze_in_grant: ack=%b ack_id=%0d, required 1 3", ack, ack_id);
        end
        freeze = 1'b0;
        req    = '0;
        cycle();
    endtask

    task automatic test_reset_mid();
        req     = 4'b0001;
        wr_data = {8'h44, 8'h33, 8'h22, 8'hFF};
        cycle();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_gnt: gnt=%b, required 0001", gnt);
        end
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            checks++;
            if (ack !== 1'b0 || q !== 8'h00 || gnt !== 4'b0000 || owner !== 2'd0) begin
                errors++;
                $display("FAIL midreset_abort[%0d]: ack=%b q=%h gnt=%b owner=%0d, required 0 00 0000 0",
                         i, ack, q, gnt, owner);
            end
        end
        reset   = 1'b0;
        req     = 4'b1111;
        wr_data = {8'h44, 8'h33, 8'h22, 8'h11};
        sb.push_back('{id: 2'd0, data: 8'h11});
        cycle();
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_next: gnt=%b, required 0001", gnt);
        end
        cycle();
        req = '0;
        cycle();
        cycle();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        req     = '0;
        freeze  = 1'b0;
        wr_data = '0;
        test_reset();
        test_single();
        test_rotation();
        test_withdraw();
        test_freeze();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d writes outstanding, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
